r5fp_dump_tx: RTL
=================

# r5fp_dump_tx

Serializes floating-point test records (operand a, operand b, result z, status flags) into the ASCII line format consumed by the FP unit benches: `DUMP: <a> <b> <z> <status>` followed by a newline, hex digits lowercase. It sits after an FP datapath (for example, adder wrap plus postproc) during FPGA or emulation runs. It feeds a byte-wide valid/ready stream (UART or trace FIFO), so hardware-produced vectors can be replayed against the simulation benches unchanged.

## Interface
- `EXP_W`, default 8: exponent width of a, b and z.
- `SIG_W`, default 23: significand width. Operand width is `W = EXP_W+SIG_W+1`.
- `STAT_W`, default 5: status width. Bits beyond 8 are not supported.
- `CNT_W`, default 16: width of the record counter.

Ports:
- `clk`, input, 1 bit: clock. All logic is on the rising edge.
- `reset`, input, 1 bit: synchronous, active-low reset.
- `in_valid`, input, 1 bit: a record is offered.
- `in_ready`, output, 1 bit: the block accepts a record.
- `in_a`, `in_b`, `in_z`, input, W bits each: operand a, operand b and result z.
- `in_status`, input, STAT_W bits: exception flags.
- `out_valid`, output, 1 bit: `out_byte` is valid.
- `out_ready`, input, 1 bit: the sink accepts the byte.
- `out_byte`, output, 8 bits: ASCII character.
- `busy`, output, 1 bit: a record is being emitted.
- `rec_count`, output, CNT_W bits: number of fully emitted records. Wraps at 2^CNT_W.

## Operation
- Digit counts:
  - `ND = ceil(W/4)` digits per operand.
  - `NS = ceil(STAT_W/4)` digits for status.
  - Each field is zero-extended on the MSB side to a whole number of nibbles and emitted most-significant nibble first.
- Line length: `L = 6 + 3*(ND+1) + NS + 1` bytes. This is 36 for the defaults.
- Byte order:
  - `'D' 'U' 'M' 'P' ':' ' '`
  - a digits, `' '`
  - b digits, `' '`
  - z digits, `' '`
  - status digits
  - `'\n'` (0x0A)
- Nibble to ASCII mapping: 0–9 map to 0x30–0x39, a–f map to 0x61–0x66.
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, capture all fields into a holding register, clear the position counter and go to PREFIX.
  - PREFIX: emit prefix character `pos`, for pos 0..5. Go to DIGIT(field 0) after pos 5 is accepted.
  - DIGIT: emit nibble `nib` (counting from ND-1 or NS-1 down to 0) of the current field. After the last nibble: go to SPACE for fields 0–2, and to EOL for field 3 (status).
  - SPACE: emit 0x20, then go to DIGIT of the next field.
  - EOL: emit 0x0A. On acceptance, increment `rec_count` and go to IDLE.
- State, counters and `out_byte` advance only on `out_valid && out_ready`. `out_byte` is held stable while stalled.
- `out_valid=1` in every state except IDLE. `busy = !IDLE`.
- Input fields are sampled only at acceptance. Later changes to the inputs do not affect the line in progress.
- The `rec_count` increment wraps from all-ones to 0.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `out_byte=0x00`, `busy=0`, `rec_count=0`. The holding register is don't-care.
- Latency: record accepted at edge k, so `'D'` appears with `out_valid=1` in cycle k+1.
- `in_ready` is a pure function of state (IDLE only). There is no combinational path from `out_ready` to `in_ready`.
- Throughput: one record per `L+1` cycles under continuous `out_ready`, because of the 1-cycle IDLE gap.
- `out_valid`, once high, stays high until the byte is accepted.
- Reset asserted mid-line: at that edge the line is abandoned, `out_valid` drops and `rec_count` clears. No partial newline is emitted.
- `in_valid` during emission is ignored. It is not queued, and `in_ready=0`.

## Structure
- Shared package `R5FP_dump_pkg` holds:
  - the state enum;
  - ASCII constants `CH_SPACE`, `CH_NL`;
  - the prefix string "DUMP: " as a 6-byte constant array;
  - the function computing ND and NS from widths.
- Sub-module `R5FP_hex_ascii`: combinational, 4-bit nibble in, 8-bit ASCII out. Instantiated once, fed by a mux over the current field and nibble.

## Test plan
1. Defaults, record a=3f800000, b=40000000, z=40400000, status=0x00, `out_ready=1` → exactly 36 bytes `DUMP: 3f800000 40000000 40400000 00\n`, and `rec_count` goes 0→1.
2. `out_ready` toggled with a random 50% duty on the scenario-1 record → identical byte sequence, `out_byte` stable during every stall, and no byte duplicated or skipped.
3. Status 5'h11, a=ffc00000 (NaN), b=7f800000, z=ffc00000 → the line ends `ffc00000 11\n`. Lowercase digits are checked.
4. EXP_W=5, SIG_W=10: a=3c00, b=4000, z=4200, status=0x04 → `DUMP: 3c00 4000 4200 04\n` (24 bytes).
5. Two records held back-to-back on `in_valid` → `in_ready=0` for the first 36 byte cycles, the second record is accepted one cycle after the `'\n'` handshake, and `rec_count=2`.
6. Reset asserted after byte 12 → `out_valid=0`, `rec_count=0` and `in_ready=1` next cycle. A following record emits a clean full line.

Source files
------------

// File: rtl/r5fp_dump_tx_pkg.sv
// Shared definitions for the FP record dump serializer: FSM states,
// ASCII constants, the line prefix and the digit-count helper.
package R5FP_dump_pkg;

    // Serializer FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_DIGIT  = 3'd2,
        ST_SPACE  = 3'd3,
        ST_EOL    = 3'd4
    } state_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_NL    = 8'h0a;

    // "DUMP: " -- element 0 is emitted first
    localparam logic [0:5][7:0] PREFIX_STR = {8'h44, 8'h55, 8'h4d, 8'h50, 8'h3a, 8'h20};
    localparam logic [2:0]      PREFIX_LAST = 3'd5;

    // Field index of the status field (a=0, b=1, z=2)
    localparam logic [1:0] FIELD_STATUS = 2'd3;

    // Number of hex digits needed to print a field of the given bit width
    function automatic int unsigned nibble_count(input int unsigned width);
        return (width + 32'd3) / 32'd4;
    endfunction

endpackage

// File: rtl/r5fp_dump_tx_hex_ascii.sv
// Nibble to lowercase ASCII hex digit.
module R5FP_hex_ascii (
    input  logic [3:0] i_nib,
    output logic [7:0] o_ascii
);

    // 0-9 map to '0'-'9', 10-15 map to 'a'-'f'
    always_comb begin
        if (i_nib < 4'd10) begin
            o_ascii = 8'h30 + {4'h0, i_nib};
        end else begin
            o_ascii = 8'h57 + {4'h0, i_nib};
        end
    end

endmodule

// File: rtl/r5fp_dump_tx.sv
// Serializes {a, b, z, status} FP test records into the ASCII line
// "DUMP: <a> <b> <z> <status>\n" on a byte-wide valid/ready stream.
module r5fp_dump_tx
    import R5FP_dump_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int SIG_W  = 23,
    parameter int STAT_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+SIG_W:0]     in_a,
    input  logic [EXP_W+SIG_W:0]     in_b,
    input  logic [EXP_W+SIG_W:0]     in_z,
    input  logic [STAT_W-1:0]        in_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic                     busy,
    output logic [CNT_W-1:0]         rec_count
);

    localparam int W     = EXP_W + SIG_W + 1;
    localparam int ND    = int'(nibble_count(W));
    localparam int NS    = int'(nibble_count(STAT_W));
    localparam int MAXD  = (ND > NS) ? ND : NS;
    localparam int FW    = MAXD * 4;
    localparam int NIB_W = $clog2(MAXD + 1);

    localparam logic [NIB_W-1:0] ND_LAST = NIB_W'(ND - 1);
    localparam logic [NIB_W-1:0] NS_LAST = NIB_W'(NS - 1);

    state_t             r_state;
    logic [2:0]         r_pos;
    logic [1:0]         r_field;
    logic [NIB_W-1:0]   r_nib;
    logic [CNT_W-1:0]   r_rec_count;

    // Holding register: all fields zero-extended to a whole number of nibbles
    logic [FW-1:0]      r_a;
    logic [FW-1:0]      r_b;
    logic [FW-1:0]      r_z;
    logic [FW-1:0]      r_status;

    logic               w_fire;
    logic               w_accept;
    logic [FW-1:0]      w_field_val;
    logic [3:0]         w_nibble;
    logic [7:0]         w_hex_char;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state != ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rec_count = r_rec_count;
    assign w_fire    = out_valid && out_ready;
    assign w_accept  = in_ready && in_valid;

    // Capture the record only at acceptance so later input changes cannot corrupt the line
    // NOTE: the holding register has no reset; it is always written before it is read,
    // so resetting it would only add logic on every data bit.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a      <= FW'(in_a);
            r_b      <= FW'(in_b);
            r_z      <= FW'(in_z);
            r_status <= FW'(in_status);
        end
    end

    // Select the field being printed; the digit counter picks the nibble within it
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_field_val = r_a;
        case (r_field)
            2'd0:    w_field_val = r_a;
            2'd1:    w_field_val = r_b;
            2'd2:    w_field_val = r_z;
            default: w_field_val = r_status;
        endcase
    end

    assign w_nibble = w_field_val[{r_nib, 2'b00} +: 4];

    R5FP_hex_ascii u_hex (
        .i_nib   (w_nibble),
        .o_ascii (w_hex_char)
    );

    // Output character is a pure function of state and counters, so it holds while stalled
    always_comb begin
        out_byte = 8'h00;
        case (r_state)
            ST_PREFIX: out_byte = PREFIX_STR[r_pos];
            ST_DIGIT:  out_byte = w_hex_char;
            ST_SPACE:  out_byte = CH_SPACE;
            ST_EOL:    out_byte = CH_NL;
            default:   out_byte = 8'h00;
        endcase
    end

    // Line sequencer: advances one character per accepted byte
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pos       <= 3'd0;
            r_field     <= 2'd0;
            r_nib       <= '0;
            r_rec_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_PREFIX;
                        r_pos   <= 3'd0;
                    end
                end
                ST_PREFIX: begin
                    if (w_fire) begin
                        if (r_pos == PREFIX_LAST) begin
                            r_state <= ST_DIGIT;
                            r_field <= 2'd0;
                            r_nib   <= ND_LAST;
                        end else begin
                            r_pos <= r_pos + 3'd1;
                        end
                    end
                end
                ST_DIGIT: begin
                    if (w_fire) begin
                        if (r_nib == '0) begin
                            r_state <= (r_field == FIELD_STATUS) ? ST_EOL : ST_SPACE;
                        end else begin
                            r_nib <= r_nib - NIB_W'(1);
                        end
                    end
                end
                ST_SPACE: begin
                    if (w_fire) begin
                        r_state <= ST_DIGIT;
                        r_field <= r_field + 2'd1;
                        r_nib   <= (r_field == 2'd2) ? NS_LAST : ND_LAST;
                    end
                end
                ST_EOL: begin
                    if (w_fire) begin
                        r_rec_count <= r_rec_count + CNT_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
